// File: rtl/cache_mem_ctrl.sv
// Memory-side miss handler: optional dirty-victim writeback, then a word-by-word block
// refill from a single-port synchronous memory with fixed 1-cycle read latency.
module cache_mem_ctrl #(
    parameter int   BLOCK_WORDS  = 16,
    parameter int   WORD_W       = 32,
    parameter int   BLOCK_ADDR_W = 8,
    localparam int  OFF_W        = $clog2(BLOCK_WORDS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [BLOCK_ADDR_W-1:0]         req_refill_blk,
    input  logic                            req_wb_en,
    input  logic [BLOCK_ADDR_W-1:0]         req_wb_blk,
    input  logic [BLOCK_WORDS*WORD_W-1:0]   req_wb_data,
    output logic                            mem_en,
    output logic                            mem_we,
    output logic [BLOCK_ADDR_W+OFF_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]               mem_wdata,
    input  logic [WORD_W-1:0]               mem_rdata,
    output logic                            fill_valid,
    output logic [OFF_W-1:0]                fill_idx,
    output logic [WORD_W-1:0]               fill_data,
    output logic                            fill_last,
    output logic                            done,
    output logic [15:0]                     wb_count,
    output logic [15:0]                     refill_count
);

    localparam int              ADDR_W   = BLOCK_ADDR_W + OFF_W;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(BLOCK_WORDS - 1);
    localparam logic [OFF_W-1:0] ZERO_OFF = {OFF_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WB    = 2'd1,
        RD    = 2'd2,
        DRAIN = 2'd3
    } ctrlStateT;

    ctrlStateT                      stateR;
    ctrlStateT                      nextStateS;
    logic [OFF_W-1:0]               offR;
    logic [OFF_W-1:0]               nextOffS;
    logic                           acceptS;
    logic                           lastOffS;

    logic [BLOCK_ADDR_W-1:0]        refillBlkR;
    logic [BLOCK_ADDR_W-1:0]        wbBlkR;
    logic [BLOCK_WORDS*WORD_W-1:0]  wbDataR;
    logic [BLOCK_ADDR_W-1:0]        nextRefillBlkS;
    logic [BLOCK_ADDR_W-1:0]        nextWbBlkS;
    logic [BLOCK_WORDS*WORD_W-1:0]  nextWbDataS;

    logic                           memEnR;
    logic                           memWeR;
    logic [ADDR_W-1:0]              memAddrR;
    logic [WORD_W-1:0]              memWdataR;
    logic [ADDR_W-1:0]              nextMemAddrS;
    logic [WORD_W-1:0]              nextMemWdataS;

    logic                           fillValidR;
    logic [OFF_W-1:0]               fillIdxR;
    logic                           fillLastR;
    logic                           doneR;
    logic                           reqReadyR;
    logic [15:0]                    wbCountR;
    logic [15:0]                    refillCountR;

    function automatic logic [15:0] satInc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Handshake and end-of-phase decode
    always_comb begin
        acceptS  = req_valid && reqReadyR;
        lastOffS = (offR == LAST_OFF);
    end

    // Phase sequencing: the offset counter stops at LAST_OFF and never wraps past it
    always_comb begin
        nextStateS = stateR;
        nextOffS   = offR;
        case (stateR)
            IDLE: begin
                if (acceptS) begin
                    nextStateS = req_wb_en ? WB : RD;
                end else begin
                    nextStateS = IDLE;
                end
                nextOffS = ZERO_OFF;
            end
            WB: begin
                if (lastOffS) begin
                    nextStateS = RD;
                    nextOffS   = ZERO_OFF;
                end else begin
                    nextStateS = WB;
                    nextOffS   = offR + OFF_W'(1);
                end
            end
            RD: begin
                if (lastOffS) begin
                    nextStateS = DRAIN;
                    nextOffS   = ZERO_OFF;
                end else begin
                    nextStateS = RD;
                    nextOffS   = offR + OFF_W'(1);
                end
            end
            DRAIN: begin
                nextStateS = IDLE;
                nextOffS   = ZERO_OFF;
            end
            default: begin
                nextStateS = IDLE;
                nextOffS   = ZERO_OFF;
            end
        endcase
    end

    // Request fields as they will be after this edge (fresh on accept, held otherwise)
    always_comb begin
        if (acceptS) begin
            nextRefillBlkS = req_refill_blk;
            nextWbBlkS     = req_wb_blk;
            nextWbDataS    = req_wb_data;
        end else begin
            nextRefillBlkS = refillBlkR;
            nextWbBlkS     = wbBlkR;
            nextWbDataS    = wbDataR;
        end
    end

    // Memory command for the cycle that follows the edge, so mem_* come straight from flops
    always_comb begin
        nextMemAddrS  = {ADDR_W{1'b0}};
        nextMemWdataS = {WORD_W{1'b0}};
        case (nextStateS)
            WB: begin
                nextMemAddrS  = {nextWbBlkS, nextOffS};
                nextMemWdataS = nextWbDataS[int'(nextOffS)*WORD_W +: WORD_W];
            end
            RD: begin
                nextMemAddrS  = {nextRefillBlkS, nextOffS};
                nextMemWdataS = {WORD_W{1'b0}};
            end
            default: begin
                nextMemAddrS  = {ADDR_W{1'b0}};
                nextMemWdataS = {WORD_W{1'b0}};
            end
        endcase
    end

    // State, offset and latched request fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateR     <= IDLE;
            offR       <= ZERO_OFF;
            refillBlkR <= {BLOCK_ADDR_W{1'b0}};
            wbBlkR     <= {BLOCK_ADDR_W{1'b0}};
            wbDataR    <= {(BLOCK_WORDS*WORD_W){1'b0}};
        end else begin
            stateR     <= nextStateS;
            offR       <= nextOffS;
            refillBlkR <= nextRefillBlkS;
            wbBlkR     <= nextWbBlkS;
            wbDataR    <= nextWbDataS;
        end
    end

    // Registered memory interface and ready flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memEnR    <= 1'b0;
            memWeR    <= 1'b0;
            memAddrR  <= {ADDR_W{1'b0}};
            memWdataR <= {WORD_W{1'b0}};
            reqReadyR <= 1'b1;
        end else begin
            memEnR    <= (nextStateS == WB) || (nextStateS == RD);
            memWeR    <= (nextStateS == WB);
            memAddrR  <= nextMemAddrS;
            memWdataR <= nextMemWdataS;
            reqReadyR <= (nextStateS == IDLE);
        end
    end

    // Fill sideband trails each read strobe by one cycle, matching the memory latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fillValidR <= 1'b0;
            fillIdxR   <= ZERO_OFF;
            fillLastR  <= 1'b0;
            doneR      <= 1'b0;
        end else begin
            fillValidR <= (stateR == RD);
            fillIdxR   <= (stateR == RD) ? offR : ZERO_OFF;
            fillLastR  <= (stateR == RD) && lastOffS;
            doneR      <= (stateR == RD) && lastOffS;
        end
    end

    // Saturating statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbCountR     <= 16'd0;
            refillCountR <= 16'd0;
        end else begin
            if ((stateR == WB) && lastOffS) begin
                wbCountR <= satInc(wbCountR);
            end else begin
                wbCountR <= wbCountR;
            end
            if (stateR == DRAIN) begin
                refillCountR <= satInc(refillCountR);
            end else begin
                refillCountR <= refillCountR;
            end
        end
    end

    assign req_ready    = reqReadyR;
    assign mem_en       = memEnR;
    assign mem_we       = memWeR;
    assign mem_addr     = memAddrR;
    assign mem_wdata    = memWdataR;
    assign fill_valid   = fillValidR;
    assign fill_idx     = fillIdxR;
    assign fill_data    = fillValidR ? mem_rdata : {WORD_W{1'b0}};
    assign fill_last    = fillLastR;
    assign done         = doneR;
    assign wb_count     = wbCountR;
    assign refill_count = refillCountR;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Self-checking bench for cache_mem_ctrl: table-driven transactions against a memory model,
// with scoreboards for memory writes, reads and refill words, plus multi-cycle corner cases.
module tb_cache_mem_ctrl;

    localparam int BW  = 16;
    localparam int WW  = 32;
    localparam int BAW = 8;
    localparam int OW  = 4;
    localparam int AW  = BAW + OW;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [BAW-1:0]   req_refill_blk;
    logic             req_wb_en;
    logic [BAW-1:0]   req_wb_blk;
    logic [BW*WW-1:0] req_wb_data;
    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WW-1:0]    mem_wdata;
    logic [WW-1:0]    mem_rdata;
    logic             fill_valid;
    logic [OW-1:0]    fill_idx;
    logic [WW-1:0]    fill_data;
    logic             fill_last;
    logic             done;
    logic [15:0]      wb_count;
    logic [15:0]      refill_count;

    cache_mem_ctrl #(.BLOCK_WORDS(BW), .WORD_W(WW), .BLOCK_ADDR_W(BAW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_refill_blk(req_refill_blk), .req_wb_en(req_wb_en),
        .req_wb_blk(req_wb_blk), .req_wb_data(req_wb_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_data(fill_data),
        .fill_last(fill_last), .done(done),
        .wb_count(wb_count), .refill_count(refill_count)
    );

    always #5 clk = ~clk;

    // Memory model: unwritten words read back a pattern of block*256 + offset
    logic [WW-1:0] memArr     [0:(1<<AW)-1];
    logic          memWritten [0:(1<<AW)-1];
    logic [WW-1:0] rdataR;

    function automatic logic [WW-1:0] pattern(input logic [AW-1:0] a);
        return {16'h0000, a[AW-1:OW], 4'h0, a[OW-1:0]};
    endfunction

    function automatic logic [WW-1:0] memRead(input logic [AW-1:0] a);
        return (memWritten[a] === 1'b1) ? memArr[a] : pattern(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                memArr[mem_addr]     <= mem_wdata;
                memWritten[mem_addr] <= 1'b1;
            end else begin
                rdataR <= memRead(mem_addr);
            end
        end
    end
    assign mem_rdata = rdataR;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } memOpT;

    typedef struct packed {
        logic [OW-1:0] idx;
        logic [WW-1:0] data;
        logic          last;
    } fillT;

    typedef struct {
        logic [BAW-1:0] refillBlk;
        logic           wbEn;
        logic [BAW-1:0] wbBlk;
        logic [WW-1:0]  wbBase;
        int             expLat;
        logic [15:0]    expWb;
        logic [15:0]    expRefill;
    } vecT;

    memOpT         wrQ[$];
    memOpT         rdQ[$];
    fillT          fillQ[$];
    logic [WW-1:0] refMem [0:(1<<AW)-1];
    int            checks = 0;
    int            fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushTxn(input logic [BAW-1:0] rb, input logic we,
                           input logic [BAW-1:0] wb, input logic [WW-1:0] base);
        memOpT op;
        fillT  f;
        if (we) begin
            for (int k = 0; k < BW; k++) begin
                op.addr = {wb, OW'(k)};
                op.data = base + WW'(k);
                wrQ.push_back(op);
                refMem[op.addr] = op.data;
            end
        end
        for (int k = 0; k < BW; k++) begin
            op.addr = {rb, OW'(k)};
            op.data = '0;
            rdQ.push_back(op);
            f.idx  = OW'(k);
            f.data = refMem[op.addr];
            f.last = (k == BW - 1);
            fillQ.push_back(f);
        end
    endtask

    task automatic sendReq(input logic [BAW-1:0] rb, input logic we, input logic [BAW-1:0] wb,
                           input logic [WW-1:0] base, input logic push, input logic keep,
                           output int waits);
        if (push) pushTxn(rb, we, wb, base);
        req_refill_blk = rb;
        req_wb_en      = we;
        req_wb_blk     = wb;
        for (int k = 0; k < BW; k++) req_wb_data[k*WW +: WW] = base + WW'(k);
        req_valid = 1'b1;
        waits = 0;
        while (!req_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            chk("ready-timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic waitDone(input int expLat, input string name);
        int   n;
        logic sawReady;
        n = 0;
        sawReady = 1'b0;
        @(negedge clk);
        while (!done && n < 100) begin
            if (req_ready) sawReady = 1'b1;
            @(negedge clk);
            n++;
        end
        chk({name, "-done-latency"}, 64'(n), 64'(expLat));
        chk({name, "-ready-while-busy"}, 64'(sawReady), 64'd0);
    endtask

    vecT vecs[5];

    initial begin
        fork
            begin : monitor
                memOpT e;
                fillT  f;
                forever begin
                    @(negedge clk);
                    if (mem_we && !mem_en) chk("we-without-en", 64'd1, 64'd0);
                    if (mem_en && mem_we) begin
                        if (wrQ.size() == 0) begin
                            chk("unexpected-write", {52'd0, mem_addr}, 64'hFFFF);
                        end else begin
                            e = wrQ.pop_front();
                            chk("write-addr", 64'(mem_addr), 64'(e.addr));
                            chk("write-data", 64'(mem_wdata), 64'(e.data));
                        end
                    end
                    if (mem_en && !mem_we) begin
                        if (rdQ.size() == 0) begin
                            chk("unexpected-read", {52'd0, mem_addr}, 64'hFFFF);
                        end else begin
                            e = rdQ.pop_front();
                            chk("read-addr", 64'(mem_addr), 64'(e.addr));
                        end
                    end
                    if (fill_valid) begin
                        if (fillQ.size() == 0) begin
                            chk("unexpected-fill", 64'(fill_idx), 64'hFFFF);
                        end else begin
                            f = fillQ.pop_front();
                            chk("fill-idx", 64'(fill_idx), 64'(f.idx));
                            chk("fill-data", 64'(fill_data), 64'(f.data));
                            chk("fill-last", 64'(fill_last), 64'(f.last));
                            chk("fill-done", 64'(done), 64'(f.last));
                        end
                    end else begin
                        if (done || fill_last) chk("done-without-fill", 64'd1, 64'd0);
                    end
                end
            end
            begin : mainSeq
                int w;
                vecs[0] = '{8'h02, 1'b0, 8'h00, 32'h0000_0000, 16, 16'd0, 16'd1};
                vecs[1] = '{8'h09, 1'b1, 8'h05, 32'h0000_00A0, 32, 16'd1, 16'd2};
                vecs[2] = '{8'h03, 1'b1, 8'h03, 32'h0000_00C0, 32, 16'd2, 16'd3};
                vecs[3] = '{8'hFF, 1'b0, 8'h00, 32'h0000_0000, 16, 16'd2, 16'd4};
                vecs[4] = '{8'h00, 1'b1, 8'hFF, 32'h1234_5600, 32, 16'd3, 16'd5};
                for (int a = 0; a < (1 << AW); a++) refMem[a] = pattern(AW'(a));

                rst = 1'b1;
                req_valid = 1'b0;
                req_refill_blk = '0;
                req_wb_en = 1'b0;
                req_wb_blk = '0;
                req_wb_data = '0;
                repeat (3) @(negedge clk);
                chk("reset-mem_en", 64'(mem_en), 64'd0);
                chk("reset-mem_addr", 64'(mem_addr), 64'd0);
                chk("reset-fill_valid", 64'(fill_valid), 64'd0);
                chk("reset-done", 64'(done), 64'd0);
                chk("reset-wb_count", 64'(wb_count), 64'd0);
                chk("reset-refill_count", 64'(refill_count), 64'd0);
                rst = 1'b0;
                @(negedge clk);
                chk("reset-ready", 64'(req_ready), 64'd1);

                for (int v = 0; v < 5; v++) begin
                    sendReq(vecs[v].refillBlk, vecs[v].wbEn, vecs[v].wbBlk, vecs[v].wbBase,
                            1'b1, 1'b0, w);
                    waitDone(vecs[v].expLat, "vec");
                    @(negedge clk);
                    chk("vec-wb_count", 64'(wb_count), 64'(vecs[v].expWb));
                    chk("vec-refill_count", 64'(refill_count), 64'(vecs[v].expRefill));
                    chk("vec-ready-after", 64'(req_ready), 64'd1);
                end

                // Second request held valid while busy: only taken on the ready cycle
                sendReq(8'h04, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, w);
                req_refill_blk = 8'h06;
                req_wb_en = 1'b1;
                req_wb_blk = 8'h0A;
                for (int k = 0; k < BW; k++) req_wb_data[k*WW +: WW] = 32'h5500_0000 + WW'(k);
                waitDone(16, "busyA");
                sendReq(8'h06, 1'b1, 8'h0A, 32'h5500_0000, 1'b1, 1'b0, w);
                chk("busy-accept-wait", 64'(w), 64'd1);
                waitDone(32, "busyB");
                @(negedge clk);
                chk("busy-wb_count", 64'(wb_count), 64'd4);
                chk("busy-refill_count", 64'(refill_count), 64'd7);

                // Reset while the victim's word 8 is presented: words 0..7 already committed
                sendReq(8'h08, 1'b1, 8'h07, 32'h0000_00E0, 1'b0, 1'b0, w);
                for (int k = 0; k <= 8; k++) wrQ.push_back('{addr: {8'h07, OW'(k)}, data: 32'hE0 + WW'(k)});
                repeat (9) @(negedge clk);
                #2 rst = 1'b1;
                #1;
                chk("midrst-mem_en", 64'(mem_en), 64'd0);
                chk("midrst-mem_we", 64'(mem_we), 64'd0);
                chk("midrst-mem_addr", 64'(mem_addr), 64'd0);
                chk("midrst-mem_wdata", 64'(mem_wdata), 64'd0);
                chk("midrst-fill_valid", 64'(fill_valid), 64'd0);
                chk("midrst-wb_count", 64'(wb_count), 64'd0);
                chk("midrst-refill_count", 64'(refill_count), 64'd0);
                for (int k = 0; k < 8; k++) refMem[{8'h07, OW'(k)}] = 32'hE0 + WW'(k);
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                chk("midrst-ready", 64'(req_ready), 64'd1);
                for (int k = 0; k < BW; k++)
                    chk("midrst-victim-word", 64'(memRead({8'h07, OW'(k)})), 64'(refMem[{8'h07, OW'(k)}]));
                sendReq(8'h07, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, w);
                waitDone(16, "postrst");
                @(negedge clk);
                chk("postrst-refill_count", 64'(refill_count), 64'd1);
                chk("postrst-wb_count", 64'(wb_count), 64'd0);

                // Saturation from a preloaded count
                force dut.refillCountR = 16'hFFFE;
                #1;
                release dut.refillCountR;
                #1;
                chk("sat-preload", 64'(refill_count), 64'hFFFE);
                for (int r = 0; r < 2; r++) begin
                    sendReq(8'h01, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, w);
                    waitDone(16, "sat");
                    @(negedge clk);
                    chk("sat-refill_count", 64'(refill_count), 64'hFFFF);
                end

                repeat (3) @(negedge clk);
                chk("end-wrQ-empty", 64'(wrQ.size()), 64'd0);
                chk("end-rdQ-empty", 64'(rdQ.size()), 64'd0);
                chk("end-fillQ-empty", 64'(fillQ.size()), 64'd0);
                $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
                $finish;
            end
        join
    end

endmodule
